// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared sizes, state encoding and fill-target type for the cache fill arbiter
// Contents: ADDR_W, DATA_W, WORDS_PER_LINE, WORD_BYTES, derived index/offset widths,
//           state_t (arbiter FSM states), target_t (which cache owns a fill), line_base().
package cache_pkg;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_BYTES     = 2;

  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE);
  localparam int LINE_OFF_W = $clog2(WORDS_PER_LINE * WORD_BYTES);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS_PER_LINE * WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    TGT_I = 1'b0,
    TGT_D = 1'b1
  } target_t;

  // Byte address of the first word of the line containing addr.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~LINE_MASK;
  endfunction
endpackage

// File: rtl/line_fill_sequencer.sv
// rtl/line_fill_sequencer.sv - issue/return counters and read address generation for one line fill
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   run           high while the arbiter is in FILL; counters sit at zero otherwise
//   base          line-aligned byte address of the line being filled
//   rvalid        memory read data valid
//   issue_en      a word read is issued this cycle
//   issue_addr    byte address of the word being issued
//   ret_we        a returned word is being delivered this cycle
//   ret_word      word index of the returned word
//   ret_last      the returned word is the last word of the line
module line_fill_sequencer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_W-1:0]     base,
  input  logic                  rvalid,
  output logic                  issue_en,
  output logic [ADDR_W-1:0]     issue_addr,
  output logic                  ret_we,
  output logic [WORD_IDX_W-1:0] ret_word,
  output logic                  ret_last
);
  // One extra bit so the counter can hold WORDS_PER_LINE, meaning "all words issued".
  logic [WORD_IDX_W:0]   issue_cnt;
  logic [WORD_IDX_W-1:0] ret_cnt;
  logic [LINE_OFF_W-1:0] offset;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue_en) issue_cnt <= issue_cnt + 1'b1;
      if (rvalid)   ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  assign issue_en = run && !issue_cnt[WORD_IDX_W];

  // base has its in-line offset bits cleared, so OR-ing the offset never carries out of the line.
  assign offset     = LINE_OFF_W'(issue_cnt[WORD_IDX_W-1:0] * WORD_BYTES);
  assign issue_addr = base | ADDR_W'(offset);

  assign ret_we   = run && rvalid;
  assign ret_word = ret_cnt;
  assign ret_last = ret_we && (ret_cnt == WORD_IDX_W'(WORDS_PER_LINE - 1));
endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - arbitrates I-fill, D-fill and D-store onto one main-memory port
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   i_miss, i_miss_addr                   I-cache line fill request (held until i_fill_done)
//   d_miss, d_miss_addr                   D-cache line fill request (held until d_fill_done)
//   d_write_req/addr/data, d_write_ack    D-cache store request and its issue pulse
//   mem_enable, mem_wr, mem_addr,
//   mem_wdata, mem_rdata, mem_rvalid      memory port (fixed latency, in-order returns)
//   fill_data, fill_word                  returned word and its index within the line
//   i_fill_we, d_fill_we                  write strobes into the owning cache line
//   i_fill_done, d_fill_done              one-cycle fill completion pulses
//   busy                                  arbiter not idle
module cache_fill_arbiter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss,
  input  logic [ADDR_W-1:0]     i_miss_addr,
  input  logic                  d_miss,
  input  logic [ADDR_W-1:0]     d_miss_addr,
  input  logic                  d_write_req,
  input  logic [ADDR_W-1:0]     d_write_addr,
  input  logic [DATA_W-1:0]     d_write_data,
  output logic                  d_write_ack,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  i_fill_we,
  output logic                  d_fill_we,
  output logic                  i_fill_done,
  output logic                  d_fill_done,
  output logic                  busy
);
  state_t              state;
  target_t             target;
  target_t             last_fill;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic                  run;
  logic                  issue_en;
  logic [ADDR_W-1:0]     issue_addr;
  logic                  ret_we;
  logic [WORD_IDX_W-1:0] ret_word;
  logic                  ret_last;
  logic                  grant_i;

  // With both misses pending, the cache that did not own the previous fill wins.
  assign grant_i = i_miss && (!d_miss || last_fill == TGT_D);
  assign run     = (state == ST_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= TGT_I;
      last_fill <= TGT_I;
      base      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (d_write_req) begin
            wr_addr <= d_write_addr;
            wr_data <= d_write_data;
            state   <= ST_WRITE;
          end else if (i_miss || d_miss) begin
            target <= grant_i ? TGT_I : TGT_D;
            base   <= line_base(grant_i ? i_miss_addr : d_miss_addr);
            state  <= ST_FILL;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_FILL:  if (ret_last) state <= ST_DONE;
        ST_DONE: begin
          last_fill <= target;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  line_fill_sequencer u_seq (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .base       (base),
    .rvalid     (mem_rvalid),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .ret_we     (ret_we),
    .ret_word   (ret_word),
    .ret_last   (ret_last)
  );

  assign d_write_ack = (state == ST_WRITE);
  assign mem_enable  = (state == ST_WRITE) || issue_en;
  assign mem_wr      = (state == ST_WRITE);
  assign mem_addr    = (state == ST_WRITE) ? wr_addr : (issue_en ? issue_addr : '0);
  assign mem_wdata   = (state == ST_WRITE) ? wr_data : '0;

  // Returns are only steered while filling; stale returns after a reset are dropped here.
  assign fill_data   = ret_we ? mem_rdata : '0;
  assign fill_word   = ret_we ? ret_word : '0;
  assign i_fill_we   = ret_we && (target == TGT_I);
  assign d_fill_we   = ret_we && (target == TGT_D);
  assign i_fill_done = (state == ST_DONE) && (target == TGT_I);
  assign d_fill_done = (state == ST_DONE) && (target == TGT_D);
  assign busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter
module tb_cache_fill_arbiter;
  localparam int LAT  = 4;
  localparam int MAXC = 96;

  typedef struct packed {
    logic        busy;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic        ife;
    logic        dfe;
    logic [2:0]  word;
    logic [15:0] data;
    logic        idone;
    logic        ddone;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_write_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_write_addr, d_write_data;
  logic        d_write_ack, mem_enable, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   lf_d   = 1'b0;
  logic [15:0] salt;

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_write_req(d_write_req), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
    .d_write_ack(d_write_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy)
  );

  // Memory contents are a fixed scramble of the address.
  function automatic logic [15:0] mdata(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  // Fixed-latency read pipe: a read issued in cycle n returns in cycle n+LAT-1.
  logic [LAT-2:0] pv = '0;
  logic [15:0]    pd [LAT-1];
  always @(posedge clk) begin
    pv[0] <= mem_enable && !mem_wr;
    pd[0] <= mdata(mem_addr);
    for (int k = 1; k < LAT - 1; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end
  assign mem_rvalid = pv[LAT-2];
  assign mem_rdata  = pd[LAT-2];

  function automatic rec_t observe();
    rec_t o;
    o.busy = busy;       o.en = mem_enable;   o.wr = mem_wr;
    o.addr = mem_addr;   o.wdata = mem_wdata; o.ack = d_write_ack;
    o.ife = i_fill_we;   o.dfe = d_fill_we;   o.word = fill_word;
    o.data = fill_data;  o.idone = i_fill_done; o.ddone = d_fill_done;
    return o;
  endfunction

  task automatic check_rec(input string tag, input int c, input rec_t e, input bit masked);
    rec_t o;
    o = observe();
    if (masked) begin
      if (!e.en) o.addr = '0;
      if (!e.wr) o.wdata = '0;
      if (!(e.ife || e.dfe)) begin
        o.word = '0;
        o.data = '0;
      end
    end
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, o, e);
    end
  endtask

  // Builds the expected per-cycle trace from the arbitration rules, then drives and checks it.
  // Cycle 0 starts at the next negedge; a request with arrival a is first seen by the decision in cycle a.
  task automatic run_scn(input string tag,
                         input bit hw, input int wa, input logic [15:0] waddr, input logic [15:0] wdat,
                         input bit hi, input int ia, input logic [15:0] iaddr,
                         input bit hd, input int da, input logic [15:0] daddr);
    rec_t        exp_tr [MAXC];
    int          wc, ic, dc, t, len, r;
    bit          ws, is_done, ds, pi, pd_, pick_i;
    logic [15:0] b;
    for (int c = 0; c < MAXC; c++) exp_tr[c] = '0;
    wc = MAXC; ic = MAXC; dc = MAXC;
    ws = !hw; is_done = !hi; ds = !hd;
    t = 0;
    while (!(ws && is_done && ds) && t < MAXC - 16) begin
      pi  = !is_done && ia <= t;
      pd_ = !ds && da <= t;
      if (!ws && wa <= t) begin
        exp_tr[t+1].busy = 1; exp_tr[t+1].en = 1; exp_tr[t+1].wr = 1;
        exp_tr[t+1].addr = waddr; exp_tr[t+1].wdata = wdat; exp_tr[t+1].ack = 1;
        wc = t + 1; ws = 1; t += 2;
      end else if (pi || pd_) begin
        pick_i = pi && (!pd_ || lf_d);
        b = (pick_i ? iaddr : daddr) & 16'hFFF0;
        for (int c = t + 1; c <= t + 12; c++) exp_tr[c].busy = 1;
        for (int k = 0; k < 8; k++) begin
          exp_tr[t+1+k].en   = 1;
          exp_tr[t+1+k].addr = b + 16'(k * 2);
          r = t + 1 + k + LAT - 1;
          exp_tr[r].ife  = pick_i;
          exp_tr[r].dfe  = !pick_i;
          exp_tr[r].word = 3'(k);
          exp_tr[r].data = mdata(b + 16'(k * 2));
        end
        if (pick_i) begin exp_tr[t+12].idone = 1; ic = t + 12; is_done = 1; end
        else        begin exp_tr[t+12].ddone = 1; dc = t + 12; ds = 1; end
        lf_d = !pick_i;
        t += 13;
      end else begin
        t++;
      end
    end
    len = t + 2;
    n_cmp++;
    assert (ws && is_done && ds) else begin
      n_fail++;
      $error("FAIL %s schedule: observed unserved expected all served", tag);
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      check_rec(tag, c, exp_tr[c], 1'b1);
      d_write_req  = hw && wa <= c && c < wc;
      i_miss       = hi && ia <= c && c < ic;
      d_miss       = hd && da <= c && c < dc;
      d_write_addr = waddr; d_write_data = wdat;
      i_miss_addr  = iaddr; d_miss_addr  = daddr;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rw, ri, rd;
    salt = 16'($urandom);
    rst = 1'b1;
    i_miss = 0; d_miss = 0; d_write_req = 0;
    i_miss_addr = '0; d_miss_addr = '0; d_write_addr = '0; d_write_data = '0;

    @(negedge clk); check_rec("reset_a", 0, '0, 1'b0);
    @(negedge clk); check_rec("reset_b", 1, '0, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a fill with reads still in flight.
    @(negedge clk);
    i_miss = 1; i_miss_addr = 16'h5A5C;
    repeat (5) @(negedge clk);
    n_cmp++;
    assert (busy === 1'b1 && mem_enable === 1'b1) else begin
      n_fail++;
      $error("FAIL midfill_active: observed busy=%b en=%b expected 1 1", busy, mem_enable);
    end
    rst = 1'b1; i_miss = 0;
    @(negedge clk); check_rec("rst_mid_a", 0, '0, 1'b0);
    @(negedge clk); check_rec("rst_mid_b", 1, '0, 1'b0);
    rst = 1'b0;
    lf_d = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); check_rec("post_rst", c, '0, 1'b0);
    end

    run_scn("both_miss",   0, 0, 16'h0, 16'h0,     1, 0, 16'h2468, 1, 0, 16'h8642);
    run_scn("single_i",    0, 0, 16'h0, 16'h0,     1, 0, 16'h123A, 0, 0, 16'h0);
    run_scn("store_prio",  1, 0, 16'h4000, 16'hBEEF, 1, 0, 16'h0F00, 0, 0, 16'h0);
    run_scn("store_fill",  1, 3, 16'h7002, 16'h1357, 0, 0, 16'h0,  1, 0, 16'h3456);
    run_scn("addr_wrap",   0, 0, 16'h0, 16'h0,     0, 0, 16'h0,    1, 0, 16'hFFF5);

    for (int n = 0; n < 10; n++) begin
      rw = 1'($urandom); ri = 1'($urandom); rd = 1'($urandom);
      if (!(rw || ri || rd)) ri = 1;
      run_scn($sformatf("rand%0d", n),
              rw, int'($urandom_range(0, 12)), 16'($urandom), 16'($urandom),
              ri, int'($urandom_range(0, 12)), 16'($urandom),
              rd, int'($urandom_range(0, 12)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
